// File: rtl/regfile_writeback_sink.sv
// Writeback-terminating register file: 16 x DATA_W storage, two bypassed read
// ports, and a pending-write scoreboard driving the decode hazard signal.
module regfile_writeback_sink #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  writeback_enable,
    input  logic [ADDR_W-1:0]     writeback_dest,
    input  logic [DATA_W-1:0]     writeback_data,
    input  logic [ADDR_W-1:0]     rs1_addr,
    input  logic [ADDR_W-1:0]     rs2_addr,
    output logic [DATA_W-1:0]     rs1_data,
    output logic [DATA_W-1:0]     rs2_data,
    input  logic                  issue_valid,
    input  logic                  issue_writes,
    input  logic [ADDR_W-1:0]     issue_dest,
    output logic                  hazard,
    output logic [2**ADDR_W-1:0]  pending_mask,
    output logic [ADDR_W:0]       pending_count
);

    localparam int unsigned NREGS = 2**ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  pend_next;
    logic [ADDR_W:0]   count_next;
    logic              wb_live;
    logic              src1_haz;
    logic              src2_haz;

    assign wb_live = writeback_enable && (writeback_dest != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_live) begin
            regs[writeback_dest] <= writeback_data;
        end
    end

    // A new producer issued in the same cycle as the old one retires keeps the bit set.
    always_comb begin
        pend_next  = '0;
        count_next = '0;
        for (int unsigned i = 1; i < NREGS; i++) begin
            if (issue_valid && issue_writes && (issue_dest == ADDR_W'(i))) begin
                pend_next[i] = 1'b1;
            end else if (writeback_enable && (writeback_dest == ADDR_W'(i))) begin
                pend_next[i] = 1'b0;
            end else begin
                pend_next[i] = pending_mask[i];
            end
            count_next = count_next + {{ADDR_W{1'b0}}, pend_next[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_mask  <= '0;
            pending_count <= '0;
        end else begin
            pending_mask  <= pend_next;
            pending_count <= count_next;
        end
    end

    always_comb begin
        rs1_data = '0;
        if (rs1_addr != '0) begin
            if (writeback_enable && (writeback_dest == rs1_addr)) begin
                rs1_data = writeback_data;
            end else begin
                rs1_data = regs[rs1_addr];
            end
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_addr != '0) begin
            if (writeback_enable && (writeback_dest == rs2_addr)) begin
                rs2_data = writeback_data;
            end else begin
                rs2_data = regs[rs2_addr];
            end
        end
    end

    // A writeback landing this cycle resolves the hazard for its register.
    assign src1_haz = (rs1_addr != '0) && pending_mask[rs1_addr]
                      && !(writeback_enable && (writeback_dest == rs1_addr));
    assign src2_haz = (rs2_addr != '0) && pending_mask[rs2_addr]
                      && !(writeback_enable && (writeback_dest == rs2_addr));
    assign hazard   = src1_haz || src2_haz;

endmodule

// File: tb/tb_regfile_writeback_sink.sv
// Directed bench for regfile_writeback_sink: an array/bitmask reference model
// checked every cycle, plus literal expectations at key points.
module tb_regfile_writeback_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic        writeback_enable;
    logic [3:0]  writeback_dest;
    logic [23:0] writeback_data;
    logic [3:0]  rs1_addr;
    logic [3:0]  rs2_addr;
    logic [23:0] rs1_data;
    logic [23:0] rs2_data;
    logic        issue_valid;
    logic        issue_writes;
    logic [3:0]  issue_dest;
    logic        hazard;
    logic [15:0] pending_mask;
    logic [4:0]  pending_count;

    int total = 0;
    int bad   = 0;

    regfile_writeback_sink #(.DATA_W(24), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .writeback_enable(writeback_enable), .writeback_dest(writeback_dest),
        .writeback_data(writeback_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .issue_valid(issue_valid), .issue_writes(issue_writes), .issue_dest(issue_dest),
        .hazard(hazard), .pending_mask(pending_mask), .pending_count(pending_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: architectural values and busy bits.
    logic [23:0] m_regs [16];
    logic [15:0] m_pend;
    bit          model_valid = 0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) m_regs[i] = '0;
            m_pend = '0;
            model_valid = 1;
        end else begin
            if (writeback_enable) begin
                if (writeback_dest != 0) m_regs[writeback_dest] = writeback_data;
                m_pend[writeback_dest] = 1'b0;
            end
            if (issue_valid && issue_writes && issue_dest != 0) m_pend[issue_dest] = 1'b1;
        end
    end

    function automatic logic [23:0] exp_read(input logic [3:0] a);
        if (a == 0) return '0;
        if (writeback_enable && writeback_dest == a) return writeback_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [3:0] a);
        return (a != 0) && m_pend[a] && !(writeback_enable && writeback_dest == a);
    endfunction

    always @(negedge clk) begin
        if (model_valid) begin
            chk("model_rs1", rs1_data, exp_read(rs1_addr));
            chk("model_rs2", rs2_data, exp_read(rs2_addr));
            chk("model_hazard", hazard, exp_busy(rs1_addr) | exp_busy(rs2_addr));
            chk("model_mask", pending_mask, m_pend);
            chk("model_count", pending_count, $countones(m_pend));
        end
    end

    // Apply one cycle of inputs just after a rising edge, return at the falling edge.
    task automatic step(input logic r, input logic we, input logic [3:0] wd,
                        input logic [23:0] wdat, input logic [3:0] a1, input logic [3:0] a2,
                        input logic iv, input logic iw, input logic [3:0] id);
        @(posedge clk);
        #1;
        rst = r; writeback_enable = we; writeback_dest = wd; writeback_data = wdat;
        rs1_addr = a1; rs2_addr = a2; issue_valid = iv; issue_writes = iw; issue_dest = id;
        @(negedge clk);
    endtask

    initial begin
        rst = 1; writeback_enable = 0; writeback_dest = 0; writeback_data = 0;
        rs1_addr = 0; rs2_addr = 0; issue_valid = 0; issue_writes = 0; issue_dest = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 5, 0, 0, 0, 0);
        chk("rst_rs1", rs1_data, 24'h0);
        chk("rst_rs2", rs2_data, 24'h0);
        chk("rst_mask", pending_mask, 16'h0);
        chk("rst_count", pending_count, 5'd0);
        chk("rst_hazard", hazard, 1'b0);

        step(0, 1, 3, 24'hABCDEF, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 3, 0, 0, 0, 0);
        chk("readback_r3", rs1_data, 24'hABCDEF);
        step(0, 1, 0, 24'h123456, 0, 0, 0, 0, 0);
        chk("r0_bypass", rs2_data, 24'h0);
        step(0, 0, 0, 0, 3, 0, 0, 0, 0);
        chk("r0_read", rs2_data, 24'h0);

        step(0, 1, 7, 24'h000111, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 7, 7, 0, 0, 0);
        chk("r7_old", rs1_data, 24'h000111);
        step(0, 1, 7, 24'h00FFFF, 7, 7, 0, 0, 0);
        chk("bypass_rs1", rs1_data, 24'h00FFFF);
        chk("bypass_rs2", rs2_data, 24'h00FFFF);
        step(0, 0, 0, 0, 7, 0, 0, 0, 0);
        chk("r7_new", rs1_data, 24'h00FFFF);

        step(0, 0, 0, 0, 0, 0, 1, 1, 4);
        step(0, 0, 0, 0, 4, 0, 0, 0, 0);
        chk("sb_mask4", pending_mask, 16'h0010);
        chk("sb_count1", pending_count, 5'd1);
        chk("sb_hazard", hazard, 1'b1);
        step(0, 1, 4, 24'h000044, 4, 0, 0, 0, 0);
        chk("sb_resolved", hazard, 1'b0);
        step(0, 0, 0, 0, 0, 4, 0, 0, 0);
        chk("sb_mask_clr", pending_mask, 16'h0);
        chk("sb_count0", pending_count, 5'd0);
        chk("sb_r4", rs2_data, 24'h000044);

        step(0, 0, 0, 0, 0, 0, 1, 1, 9);
        step(0, 1, 9, 24'h000099, 0, 0, 1, 1, 9);
        step(0, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("sbc_mask", pending_mask, 16'h0200);
        chk("sbc_count", pending_count, 5'd1);
        step(0, 1, 6, 24'h000066, 0, 0, 1, 0, 5);
        chk("iss0_mask", pending_mask, 16'h0200);
        step(0, 0, 0, 0, 0, 9, 0, 0, 0);
        chk("noop_mask", pending_mask, 16'h0200);
        chk("noop_hazard_rs2", hazard, 1'b1);

        step(0, 1, 9, 24'h000009, 0, 0, 1, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1, 1, 2);
        step(0, 0, 0, 0, 0, 0, 1, 1, 15);
        step(0, 0, 0, 0, 15, 0, 0, 0, 0);
        chk("mid_mask", pending_mask, 16'h8006);
        chk("mid_count", pending_count, 5'd3);
        chk("mid_hazard", hazard, 1'b1);
        step(1, 1, 5, 24'h555555, 0, 0, 1, 1, 5);
        step(0, 0, 0, 0, 15, 3, 0, 0, 0);
        chk("post_rst_mask", pending_mask, 16'h0);
        chk("post_rst_count", pending_count, 5'd0);
        chk("post_rst_hazard", hazard, 1'b0);
        chk("post_rst_r3", rs2_data, 24'h0);
        step(0, 0, 0, 0, 5, 7, 0, 0, 0);
        chk("post_rst_r5", rs1_data, 24'h0);
        chk("post_rst_r7", rs2_data, 24'h0);

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
